// File: rtl/perceptron_pkg.sv
// Shared types and constants for the 7-input bit-serial perceptron trainer.
// Pure definitions: no latency, no flow control.
package perceptron_pkg;
    localparam int NUM_INPUTS = 7;
    localparam int WEIGHT_W   = 8;
    localparam int ACC_W      = 11;
    localparam int SUM_W      = 12;
    localparam int IDX_W      = 3;

    localparam logic [WEIGHT_W-1:0] W_RESET  = 8'h80;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DECIDE,
        UPDATE,
        DONE
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/perceptron_trainer_sat_addsub8.sv
// Combinational 8-bit unsigned saturating add (sub=0) or subtract (sub=1).
// Zero latency, no flow control.
module sat_addsub8
    import perceptron_pkg::*;
(
    input  logic [WEIGHT_W-1:0] a,
    input  logic [WEIGHT_W-1:0] b,
    input  logic                sub,
    output logic [WEIGHT_W-1:0] y
);
    logic [WEIGHT_W:0] sum_w;
    logic [WEIGHT_W:0] diff_w;

    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, b};
        diff_w = {1'b0, a} - {1'b0, b};
        if (sub) begin
            y = diff_w[WEIGHT_W] ? '0 : diff_w[WEIGHT_W-1:0];
        end else begin
            y = sum_w[WEIGHT_W] ? '1 : sum_w[WEIGHT_W-1:0];
        end
    end
endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: bit-serial accumulate, threshold decide, saturating weight update.
// Latency 9 cycles (no update) or 16 (update); sample_ready only in IDLE, busy offers are dropped.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int THRESHOLD = 128,
    parameter int LR        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [NUM_INPUTS-1:0]        sample_bits,
    input  logic                         sample_label,
    input  logic                         train_en,
    input  logic                         clear_errors,
    output logic                         done,
    output logic                         prediction,
    output logic                         mispredict,
    output logic [NUM_INPUTS*WEIGHT_W-1:0] weights_flat,
    output logic [WEIGHT_W-1:0]          bias,
    output logic [7:0]                   error_count
);
    localparam logic [SUM_W-1:0]    THRESH_V = SUM_W'(THRESHOLD);
    localparam logic [WEIGHT_W-1:0] LR_V     = WEIGHT_W'(LR);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [NUM_INPUTS-1:0] x_q, x_d;
    logic                  label_q, label_d;
    logic                  train_q, train_d;
    logic [WEIGHT_W-1:0]   w_q [NUM_INPUTS];
    logic [WEIGHT_W-1:0]   w_d [NUM_INPUTS];
    logic [WEIGHT_W-1:0]   bias_q, bias_d;
    logic [7:0]            err_q, err_d;
    logic                  pred_q, pred_d;
    logic                  mis_q, mis_d;

    logic [WEIGHT_W-1:0]   w_sel;
    logic [WEIGHT_W-1:0]   w_upd;
    logic [WEIGHT_W-1:0]   bias_upd;
    logic [SUM_W-1:0]      sum;
    logic                  decide_pred;
    logic                  decide_mis;
    logic                  err_inc;

    // Label 1 pulls weights up, label 0 pulls them down.
    sat_addsub8 u_w_sat (
        .a   (w_sel),
        .b   (LR_V),
        .sub (~label_q),
        .y   (w_upd)
    );

    sat_addsub8 u_b_sat (
        .a   (bias_q),
        .b   (LR_V),
        .sub (~label_q),
        .y   (bias_upd)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        x_d     = x_q;
        label_d = label_q;
        train_d = train_q;
        w_d     = w_q;
        bias_d  = bias_q;
        err_d   = err_q;
        pred_d  = pred_q;
        mis_d   = mis_q;
        err_inc = 1'b0;

        w_sel       = w_q[idx_q];
        sum         = {1'b0, acc_q} + {{(SUM_W-WEIGHT_W){1'b0}}, bias_q};
        decide_pred = (sum >= THRESH_V);
        decide_mis  = (decide_pred != label_q);

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    x_d     = sample_bits;
                    label_d = sample_label;
                    train_d = train_en;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (x_q[idx_q]) begin
                    acc_d = acc_q + ACC_W'(w_sel);
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DECIDE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DECIDE: begin
                err_inc = decide_mis;
                if (decide_mis && train_q) begin
                    idx_d   = '0;
                    state_d = UPDATE;
                end else begin
                    pred_d  = decide_pred;
                    mis_d   = decide_mis;
                    state_d = DONE;
                end
            end
            UPDATE: begin
                if (x_q[idx_q]) begin
                    w_d[idx_q] = w_upd;
                end
                if (idx_q == '0) begin
                    bias_d = bias_upd;
                end
                if (idx_q == LAST_IDX) begin
                    // Only a mispredict reaches UPDATE, so the prediction was the inverted label.
                    pred_d  = ~label_q;
                    mis_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_errors) begin
            err_d = '0;
        end else if (err_inc) begin
            err_d = sat_inc8(err_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            label_q <= 1'b0;
            train_q <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                w_q[i] <= W_RESET;
            end
            bias_q  <= '0;
            err_q   <= '0;
            pred_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            label_q <= label_d;
            train_q <= train_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                w_q[i] <= w_d[i];
            end
            bias_q  <= bias_d;
            err_q   <= err_d;
            pred_q  <= pred_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        weights_flat = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            weights_flat[i*WEIGHT_W +: WEIGHT_W] = w_q[i];
        end
    end

    assign sample_ready = (state_q == IDLE);
    assign done         = (state_q == DONE);
    assign prediction   = pred_q;
    assign mispredict   = mis_q;
    assign bias         = bias_q;
    assign error_count  = err_q;
endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Online training engine for the 7-input serial perceptron. It sits on the sample-producer side of the inference block: accepts a labelled 7-bit sample, computes the prediction bit-serially with the current weights, applies the perceptron learning rule on a mispredict, and exports the updated weight set for loading into the inference datapath. One sample is processed at a time, one input bit per cycle, matching the inference block's bit-serial cadence.

## Interface
- `THRESHOLD`, default 128: decision threshold; predict 1 iff `acc + bias >= THRESHOLD` (12-bit compare).
- `LR`, default 8: learning-rate step, 8-bit unsigned, added to or subtracted from each affected weight.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `sample_valid` in 1: sample offer.
- `sample_ready` out 1: high only in IDLE; transfer on `sample_valid && sample_ready`.
- `sample_bits` in 7: input vector x[6:0]; captured on transfer.
- `sample_label` in 1: target class; captured on transfer.
- `train_en` in 1: captured on transfer; 0 = inference only, no update.
- `clear_errors` in 1: synchronous clear of `error_count`.
- `done` out 1: one-cycle pulse, result valid.
- `prediction` out 1: prediction for last sample; held until next `done`.
- `mispredict` out 1: `prediction != label` for last sample; held.
- `weights_flat` out 56: w[i] at bits [8i+7:8i], unsigned Q0.8 (0x80 = 0.5).
- `bias` out 8: unsigned Q0.8.
- `error_count` out 8: saturating count of mispredicts (stops at 255).

## Operation
- Reset values: every w[i] = 0x80, `bias` = 0, `error_count` = 0, `prediction`/`mispredict`/`done` = 0, `sample_ready` = 1 from the first cycle after reset, state IDLE.
- FSM states:
  - IDLE: accept on transfer, latch bits/label/train_en, clear acc, go to ACCUM with idx = 0.
  - ACCUM: each cycle `acc += x[idx] ? w[idx] : 0`, idx 0..6. Go to DECIDE after idx 6.
  - DECIDE: compute pred and mispredict. Go to UPDATE if `mispredict && train_en`, else go to DONE.
  - UPDATE: each cycle idx 0..6 with x[idx] = 1, w[idx] moves by LR. The move is a saturating add toward 0xFF when label = 1, or a saturating subtract toward 0x00 when label = 0. Bias moves the same way in the UPDATE idx-0 cycle. Then go to DONE.
  - DONE: pulse `done`, register outputs, go to IDLE.
- `acc` is 11 bits wide (max 7×255 = 1785), so it cannot overflow and needs no saturation.
- `error_count` increments in DECIDE on a mispredict, regardless of `train_en`.
- `clear_errors` wins over a same-cycle increment.
- `sample_valid` while not in IDLE is ignored; nothing is queued.
- Weights and bias are never modified outside UPDATE.

## Timing
- Transfer at edge T. ACCUM occupies cycles T+1..T+7 and DECIDE occupies T+8.
- No update: `done` high in cycle T+9.
- Update: UPDATE occupies T+9..T+15 and `done` is high in T+16.
- `sample_ready` is high again the cycle after `done`, so the back-to-back period is 10 or 17 cycles.
- `weights_flat` and `bias` change during UPDATE. They are final and stable from the `done` cycle until the next UPDATE.
- `rst_n` low in any state takes effect at that edge: all state returns to reset values, including weights, and the in-flight sample is dropped without a `done` pulse.

## Structure
- Shared package `perceptron_pkg`:
  - `NUM_INPUTS` = 7, `WEIGHT_W` = 8, `ACC_W` = 11.
  - `W_RESET` = 8'h80.
  - FSM state enum {IDLE, ACCUM, DECIDE, UPDATE, DONE}.
- Sub-module `sat_addsub8`: combinational 8-bit unsigned saturating add/sub (inputs a, b, sub; output y). Used for both the weight and bias updates.

## Test plan
- Reset → `weights_flat` = 56'h80808080808080, `bias` = 0, `error_count` = 0, `sample_ready` = 1.
- Sample bits = 7'b0000001, label = 1, train_en = 1 → acc = 128 ≥ 128, `prediction` = 1, `mispredict` = 0, `done` at T+9, weights unchanged.
- Sample bits = 7'b0000000, label = 1, train_en = 1 → `prediction` = 0, `mispredict` = 1, `done` at T+16, `bias` = 0x08, weights unchanged, `error_count` = 1.
- Sample bits = 7'b1111111, label = 0, train_en = 1 → acc = 896, `prediction` = 1, all w = 0x78, `bias` stays at 0 (floor), `error_count` = 1. Repeat with train_en = 0 → weights unchanged, `error_count` = 2, `done` at T+9.
- THRESHOLD = 2047, bits = 7'b0000001, label = 1, 17 samples → w0 saturates at 0xFF on the 16th and stays 0xFF after the 17th; other weights stay 0x80.
- Assert `rst_n` = 0 during UPDATE cycle T+12 → no `done` pulse, weights back to 0x80, `sample_ready` = 1 the cycle after `rst_n` returns high; `sample_valid` pulses during ACCUM are ignored.
